// File: rtl/bldc_startup_sequencer.sv
// BLDC start-up sequencer: alignment, open-loop forced-commutation ramp, then
// hand-over to Hall commutation, with stall detection and fault hold-off.
module bldc_startup_sequencer #(
    parameter int         ALIGN_CYCLES     = 50000,
    parameter int         RAMP_PERIOD_INIT = 20000,
    parameter int         RAMP_PERIOD_MIN  = 2000,
    parameter int         RAMP_DEC         = 500,
    parameter logic [7:0] DUTY_ALIGN       = 8'd40,
    parameter logic [7:0] DUTY_RAMP        = 8'd64,
    parameter int         HALL_EDGES       = 6,
    parameter int         STALL_STEPS      = 24,
    parameter int         FAULT_HOLD       = 10000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] speed_set,
    input  logic [2:0] hall_signal,
    input  logic       fault,
    output logic       motor_enable,
    output logic       ol_enable,
    output logic [2:0] forced_step,
    output logic [7:0] duty,
    output logic       stall,
    output logic [2:0] state
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_ALIGN    = 3'd1;
    localparam logic [2:0] S_RAMP     = 3'd2;
    localparam logic [2:0] S_HANDOVER = 3'd3;
    localparam logic [2:0] S_RUN      = 3'd4;
    localparam logic [2:0] S_FAULT    = 3'd5;

    localparam int AW = $clog2(ALIGN_CYCLES + 1);
    localparam int PW = $clog2(RAMP_PERIOD_INIT + 1);
    localparam int EW = $clog2(HALL_EDGES + 1);
    localparam int SW = $clog2(STALL_STEPS + 1);
    localparam int HW = $clog2(FAULT_HOLD + 1);

    localparam logic [AW-1:0] ALIGN_LAST  = AW'(ALIGN_CYCLES - 1);
    localparam logic [PW-1:0] PERIOD_INIT = PW'(RAMP_PERIOD_INIT);
    localparam logic [PW-1:0] PERIOD_MIN  = PW'(RAMP_PERIOD_MIN);
    localparam logic [PW-1:0] PERIOD_DEC  =
        PW'((RAMP_DEC > RAMP_PERIOD_INIT) ? RAMP_PERIOD_INIT : RAMP_DEC);
    localparam logic [EW-1:0] EDGES_DONE  = EW'(HALL_EDGES);
    localparam logic [SW-1:0] STALL_LIMIT = SW'(STALL_STEPS);
    localparam logic [HW-1:0] HOLD_LAST   = HW'(FAULT_HOLD - 1);

    logic [2:0]    r_state, w_state;
    logic          r_motor_enable, w_motor_enable;
    logic          r_ol_enable, w_ol_enable;
    logic [2:0]    r_forced_step, w_forced_step;
    logic [7:0]    r_duty, w_duty;
    logic          r_stall, w_stall;
    logic [AW-1:0] r_align_cnt, w_align_cnt;
    logic [PW-1:0] r_step_cnt, w_step_cnt;
    logic [PW-1:0] r_period, w_period;
    logic [EW-1:0] r_edge_cnt, w_edge_cnt;
    logic [SW-1:0] r_stall_cnt, w_stall_cnt;
    logic [HW-1:0] r_hold_cnt, w_hold_cnt;
    logic [2:0]    r_hall_q;

    logic          w_go_idle;
    logic          w_hall_in_ok;
    logic          w_hall_edge;
    logic [PW-1:0] w_period_dec;
    logic [7:0]    w_slew;

    assign w_hall_in_ok = (hall_signal != 3'd0) && (hall_signal != 3'd7);
    assign w_hall_edge  = w_hall_in_ok && (r_hall_q != 3'd0) && (r_hall_q != 3'd7)
                          && (r_hall_q != hall_signal);

    // Period never drops below the floor; r_period >= PERIOD_MIN keeps the gap non-negative.
    assign w_period_dec = ((r_period - PERIOD_MIN) > PERIOD_DEC) ? (r_period - PERIOD_DEC)
                                                                  : PERIOD_MIN;

    assign w_slew = (r_duty < speed_set) ? (r_duty + 8'd1) :
                    (r_duty > speed_set) ? (r_duty - 8'd1) : r_duty;

    always_comb begin
        // NOTE: every signal gets a hold-value default first so no path infers a latch.
        w_state        = r_state;
        w_motor_enable = r_motor_enable;
        w_ol_enable    = r_ol_enable;
        w_forced_step  = r_forced_step;
        w_duty         = r_duty;
        w_stall        = r_stall;
        w_align_cnt    = r_align_cnt;
        w_step_cnt     = r_step_cnt;
        w_period       = r_period;
        w_edge_cnt     = r_edge_cnt;
        w_stall_cnt    = r_stall_cnt;
        w_hold_cnt     = r_hold_cnt;
        w_go_idle      = 1'b0;

        if (fault) begin
            w_state        = S_FAULT;
            w_motor_enable = 1'b0;
            w_ol_enable    = 1'b0;
            w_forced_step  = 3'd0;
            w_duty         = 8'd0;
            w_hold_cnt     = '0;
        end else if (!start && (r_state inside {S_ALIGN, S_RAMP, S_HANDOVER, S_RUN})) begin
            w_go_idle = 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        w_state       = S_ALIGN;
                        w_stall       = 1'b0;
                        w_ol_enable   = 1'b1;
                        w_forced_step = 3'd0;
                        w_duty        = DUTY_ALIGN;
                        w_align_cnt   = '0;
                    end
                end
                S_ALIGN: begin
                    if (r_align_cnt == ALIGN_LAST) begin
                        w_state     = S_RAMP;
                        w_duty      = DUTY_RAMP;
                        w_period    = PERIOD_INIT;
                        w_step_cnt  = '0;
                        w_edge_cnt  = '0;
                        w_stall_cnt = '0;
                    end else begin
                        w_align_cnt = r_align_cnt + 1'b1;
                    end
                end
                S_RAMP: begin
                    if (r_edge_cnt == EDGES_DONE) begin
                        w_state        = S_HANDOVER;
                        w_motor_enable = 1'b1;
                        w_ol_enable    = 1'b0;
                    end else begin
                        if (!w_hall_in_ok)
                            w_edge_cnt = '0;
                        else if (w_hall_edge)
                            w_edge_cnt = r_edge_cnt + 1'b1;

                        if (r_step_cnt == r_period - 1'b1) begin
                            w_step_cnt    = '0;
                            w_forced_step = (r_forced_step == 3'd5) ? 3'd0 : r_forced_step + 3'd1;
                            w_period      = w_period_dec;
                            // The first floor-period step reaches the floor; STALL_STEPS more declare a stall.
                            if (r_period == PERIOD_MIN) begin
                                if (r_stall_cnt == STALL_LIMIT) begin
                                    w_stall   = 1'b1;
                                    w_go_idle = 1'b1;
                                end else begin
                                    w_stall_cnt = r_stall_cnt + 1'b1;
                                end
                            end
                        end else begin
                            w_step_cnt = r_step_cnt + 1'b1;
                        end
                    end
                end
                S_HANDOVER: begin
                    w_duty = w_slew;
                    if (w_slew == speed_set)
                        w_state = S_RUN;
                end
                S_RUN: begin
                    w_duty = speed_set;
                end
                S_FAULT: begin
                    if (r_hold_cnt == HOLD_LAST) begin
                        if (!start)
                            w_go_idle = 1'b1;
                    end else begin
                        w_hold_cnt = r_hold_cnt + 1'b1;
                    end
                end
                default: w_go_idle = 1'b1;
            endcase
        end

        if (w_go_idle) begin
            w_state        = S_IDLE;
            w_motor_enable = 1'b0;
            w_ol_enable    = 1'b0;
            w_forced_step  = 3'd0;
            w_duty         = 8'd0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!reset) begin
            r_state        <= S_IDLE;
            r_motor_enable <= 1'b0;
            r_ol_enable    <= 1'b0;
            r_forced_step  <= 3'd0;
            r_duty         <= 8'd0;
            r_stall        <= 1'b0;
            r_align_cnt    <= '0;
            r_step_cnt     <= '0;
            r_period       <= '0;
            r_edge_cnt     <= '0;
            r_stall_cnt    <= '0;
            r_hold_cnt     <= '0;
            r_hall_q       <= 3'd0;
        end else begin
            r_state        <= w_state;
            r_motor_enable <= w_motor_enable;
            r_ol_enable    <= w_ol_enable;
            r_forced_step  <= w_forced_step;
            r_duty         <= w_duty;
            r_stall        <= w_stall;
            r_align_cnt    <= w_align_cnt;
            r_step_cnt     <= w_step_cnt;
            r_period       <= w_period;
            r_edge_cnt     <= w_edge_cnt;
            r_stall_cnt    <= w_stall_cnt;
            r_hold_cnt     <= w_hold_cnt;
            r_hall_q       <= hall_signal;
        end
    end

    assign state        = r_state;
    assign motor_enable = r_motor_enable;
    assign ol_enable    = r_ol_enable;
    assign forced_step  = r_forced_step;
    assign duty         = r_duty;
    assign stall        = r_stall;

endmodule

// File: tb/tb_bldc_startup_sequencer.sv
// Bench for bldc_startup_sequencer: per-cycle comparison against a phase/time
// based reference model plus directed timing checks for each scenario.
module tb_bldc_startup_sequencer;

    localparam int         P_ALIGN = 8;
    localparam int         P_INIT  = 20;
    localparam int         P_MIN   = 10;
    localparam int         P_DEC   = 5;
    localparam int         P_EDGES = 3;
    localparam int         P_STALL = 4;
    localparam int         P_HOLD  = 16;
    localparam logic [7:0] P_DA    = 8'd40;
    localparam logic [7:0] P_DR    = 8'd64;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       fault = 1'b0;
    logic [7:0] speed_set = 8'd0;
    logic [2:0] hall_signal = 3'd0;
    logic       motor_enable, ol_enable, stall;
    logic [2:0] forced_step, state;
    logic [7:0] duty;

    int checks = 0;
    int errors = 0;

    // Reference model: phase number, cycles spent in the phase, derived outputs.
    int m_state = 0, m_fs = 0, m_duty = 0, m_age = 0, m_edges = 0, m_hold = 0, m_prev_hall = 0;
    bit m_me = 0, m_ol = 0, m_stall = 0;

    bldc_startup_sequencer #(
        .ALIGN_CYCLES(P_ALIGN), .RAMP_PERIOD_INIT(P_INIT), .RAMP_PERIOD_MIN(P_MIN),
        .RAMP_DEC(P_DEC), .DUTY_ALIGN(P_DA), .DUTY_RAMP(P_DR), .HALL_EDGES(P_EDGES),
        .STALL_STEPS(P_STALL), .FAULT_HOLD(P_HOLD)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .speed_set(speed_set),
        .hall_signal(hall_signal), .fault(fault), .motor_enable(motor_enable),
        .ol_enable(ol_enable), .forced_step(forced_step), .duty(duty), .stall(stall),
        .state(state)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic bit hv(input int h);
        return (h >= 1) && (h <= 6);
    endfunction

    // Completed forced steps after t ramp cycles; step k lasts max(INIT-k*DEC, MIN).
    function automatic int ramp_steps(input int t, input bit at_min_only);
        int elapsed = 0;
        int n = 0;
        int nmin = 0;
        int per;
        for (int k = 0; k < 1000; k++) begin
            per = P_INIT - k * P_DEC;
            if (per < P_MIN) per = P_MIN;
            if (elapsed + per > t) break;
            elapsed += per;
            n++;
            if (per == P_MIN) nmin++;
        end
        return at_min_only ? nmin : n;
    endfunction

    task automatic m_idle();
        m_state = 0; m_me = 0; m_ol = 0; m_fs = 0; m_duty = 0;
    endtask

    task automatic model_edge();
        bit hedge;
        int h;
        h = int'(hall_signal);
        hedge = hv(m_prev_hall) && hv(h) && (m_prev_hall != h);
        if (!reset) begin
            m_idle(); m_stall = 0; m_age = 0; m_edges = 0; m_hold = 0;
        end else if (fault) begin
            m_state = 5; m_me = 0; m_ol = 0; m_fs = 0; m_duty = 0; m_hold = 0;
        end else if (!start && m_state >= 1 && m_state <= 4) begin
            m_idle();
        end else begin
            case (m_state)
                0: if (start) begin
                    m_state = 1; m_age = 0; m_stall = 0; m_ol = 1; m_fs = 0; m_duty = int'(P_DA);
                end
                1: begin
                    m_age++;
                    if (m_age == P_ALIGN) begin
                        m_state = 2; m_age = 0; m_edges = 0; m_duty = int'(P_DR);
                    end
                end
                2: if (m_edges == P_EDGES) begin
                    m_state = 3; m_me = 1; m_ol = 0;
                end else begin
                    if (!hv(h)) m_edges = 0;
                    else if (hedge) m_edges++;
                    m_age++;
                    m_fs = ramp_steps(m_age, 1'b0) % 6;
                    if (ramp_steps(m_age, 1'b1) > P_STALL) begin
                        m_stall = 1;
                        m_idle();
                    end
                end
                3: begin
                    if (m_duty < int'(speed_set)) m_duty++;
                    else if (m_duty > int'(speed_set)) m_duty--;
                    if (m_duty == int'(speed_set)) m_state = 4;
                end
                4: m_duty = int'(speed_set);
                5: begin
                    m_hold++;
                    if (m_hold >= P_HOLD && !start) m_idle();
                end
                default: m_idle();
            endcase
        end
        m_prev_hall = reset ? h : 0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    function automatic logic [16:0] dut_vec();
        return {state, motor_enable, ol_enable, forced_step, duty, stall};
    endfunction

    function automatic logic [16:0] mdl_vec();
        return {3'(m_state), m_me, m_ol, 3'(m_fs), 8'(m_duty), m_stall};
    endfunction

    task automatic test_reset();
        reset = 1'b0; start = 1'b1; fault = 1'b0;
        repeat (2) tick();
        checks++;
        if (dut_vec() !== 17'd0) begin
            errors++; $display("FAIL reset_values: got %h expected 0", dut_vec());
        end
        reset = 1'b1; start = 1'b0;
        tick();
        checks++;
        if (dut_vec() !== mdl_vec()) begin
            errors++; $display("FAIL reset_idle: got %h expected %h", dut_vec(), mdl_vec());
        end
    endtask

    task automatic test_nominal();
        int align_seen = 0;
        int ho_seen = 0;
        int run_seen = 0;
        speed_set = 8'd100; hall_signal = 3'd1; start = 1'b1;
        for (int i = 0; i < 300 && run_seen < 3; i++) begin
            hall_signal = (i < 38) ? 3'd1 : (i < 48) ? 3'd3 : (i < 58) ? 3'd2 : 3'd6;
            tick();
            checks++;
            if (dut_vec() !== mdl_vec()) begin
                errors++; $display("FAIL nominal i=%0d: got %h expected %h", i, dut_vec(), mdl_vec());
            end
            if (state == 3'd1) align_seen++;
            if (state == 3'd3) ho_seen++;
            if (state == 3'd4) run_seen++;
        end
        checks++;
        if (run_seen < 3) begin
            errors++; $display("FAIL nominal_timeout: run cycles %0d expected 3", run_seen);
        end
        checks++;
        if (align_seen != P_ALIGN) begin
            errors++; $display("FAIL align_length: got %0d expected %0d", align_seen, P_ALIGN);
        end
        checks++;
        if (ho_seen != 36) begin
            errors++; $display("FAIL handover_length: got %0d expected 36", ho_seen);
        end
        for (int i = 0; i < 16; i++) begin
            speed_set = (i == 8) ? 8'd0 : 8'($urandom);
            tick();
            checks++;
            if (dut_vec() !== mdl_vec()) begin
                errors++; $display("FAIL run_track i=%0d: got %h expected %h", i, dut_vec(), mdl_vec());
            end
        end
        checks++;
        if (state !== 3'd4) begin
            errors++; $display("FAIL run_state: got %0d expected 4", state);
        end
    endtask

    task automatic test_fault();
        int idle_at = 0;
        fault = 1'b1;
        tick();
        checks++;
        if (state !== 3'd5 || duty !== 8'd0 || motor_enable !== 1'b0) begin
            errors++; $display("FAIL fault_entry: got state=%0d duty=%0d expected 5/0", state, duty);
        end
        fault = 1'b0; start = 1'b0;
        for (int i = 1; i <= 40 && idle_at == 0; i++) begin
            tick();
            checks++;
            if (dut_vec() !== mdl_vec()) begin
                errors++; $display("FAIL fault_hold i=%0d: got %h expected %h", i, dut_vec(), mdl_vec());
            end
            if (state == 3'd0) idle_at = i;
        end
        checks++;
        if (idle_at != P_HOLD) begin
            errors++; $display("FAIL fault_release: got %0d cycles expected %0d", idle_at, P_HOLD);
        end
        start = 1'b1;
        repeat (4) tick();
        fault = 1'b1;
        tick();
        fault = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            checks++;
            if (dut_vec() !== mdl_vec()) begin
                errors++; $display("FAIL fault_start_held i=%0d: got %h expected %h", i, dut_vec(), mdl_vec());
            end
        end
        checks++;
        if (state !== 3'd5) begin
            errors++; $display("FAIL fault_stays: got %0d expected 5", state);
        end
        start = 1'b0;
        tick();
        checks++;
        if (state !== 3'd0) begin
            errors++; $display("FAIL fault_drop_start: got %0d expected 0", state);
        end
    endtask

    task automatic test_invalid_hall();
        int codes[6] = '{3, 0, 2, 6, 4, 5};
        int len;
        speed_set = 8'($urandom_range(100, 200));
        hall_signal = 3'd1; start = 1'b1;
        for (int i = 0; i < 20 && state != 3'd2; i++) begin
            tick();
            checks++;
            if (dut_vec() !== mdl_vec()) begin
                errors++; $display("FAIL inv_align i=%0d: got %h expected %h", i, dut_vec(), mdl_vec());
            end
        end
        checks++;
        if (state !== 3'd2) begin
            errors++; $display("FAIL inv_ramp_timeout: got %0d expected 2", state);
        end
        for (int c = 0; c < 6; c++) begin
            hall_signal = 3'(codes[c]);
            len = $urandom_range(3, 6);
            for (int k = 0; k < len; k++) begin
                tick();
                checks++;
                if (dut_vec() !== mdl_vec()) begin
                    errors++; $display("FAIL inv_hall code=%0d: got %h expected %h", codes[c], dut_vec(), mdl_vec());
                end
            end
            if (c == 4) begin
                checks++;
                if (state !== 3'd2) begin
                    errors++; $display("FAIL inv_no_handover: got %0d expected 2", state);
                end
            end
        end
        checks++;
        if (state !== 3'd3) begin
            errors++; $display("FAIL inv_handover: got %0d expected 3", state);
        end
    endtask

    task automatic test_stall_wrap();
        int ramp_n = 0;
        bit done = 0;
        int seq[$];
        start = 1'b0;
        tick();
        hall_signal = 3'd5; start = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            tick();
            checks++;
            if (dut_vec() !== mdl_vec()) begin
                errors++; $display("FAIL stall i=%0d: got %h expected %h", i, dut_vec(), mdl_vec());
            end
            if (state == 3'd2) begin
                ramp_n++;
                if (seq.size() == 0 || int'(forced_step) != seq[$]) seq.push_back(int'(forced_step));
            end
            if (ramp_n > 0 && state == 3'd0) done = 1;
        end
        checks++;
        if (!done || ramp_n != P_INIT + (P_INIT - P_DEC) + P_MIN * (P_STALL + 1)) begin
            errors++; $display("FAIL stall_time: got %0d ramp cycles expected %0d", ramp_n,
                               P_INIT + (P_INIT - P_DEC) + P_MIN * (P_STALL + 1));
        end
        checks++;
        if (seq.size() != 7) begin
            errors++; $display("FAIL wrap_len: got %0d expected 7", seq.size());
        end else begin
            for (int k = 0; k < 7; k++) begin
                checks++;
                if (seq[k] != k % 6) begin
                    errors++; $display("FAIL wrap_seq k=%0d: got %0d expected %0d", k, seq[k], k % 6);
                end
            end
        end
        start = 1'b0;
        tick();
        checks++;
        if (state !== 3'd0 || stall !== 1'b1) begin
            errors++; $display("FAIL stall_hold: got state=%0d stall=%0d expected 0/1", state, stall);
        end
        start = 1'b1;
        tick();
        checks++;
        if (state !== 3'd1 || stall !== 1'b0) begin
            errors++; $display("FAIL stall_clear: got state=%0d stall=%0d expected 1/0", state, stall);
        end
    endtask

    task automatic test_stop_reset();
        int n;
        for (int i = 0; i < 20 && state != 3'd2; i++) tick();
        n = $urandom_range(1, 15);
        for (int k = 0; k < n; k++) begin
            tick();
            checks++;
            if (dut_vec() !== mdl_vec()) begin
                errors++; $display("FAIL stop_ramp k=%0d: got %h expected %h", k, dut_vec(), mdl_vec());
            end
        end
        start = 1'b0;
        tick();
        checks++;
        if (dut_vec() !== 17'd0) begin
            errors++; $display("FAIL stop_idle: got %h expected 0", dut_vec());
        end
        speed_set = 8'd250; start = 1'b1;
        for (int i = 0; i < 20 && state != 3'd2; i++) tick();
        for (int c = 1; c <= 4; c++) begin
            hall_signal = 3'(c);
            repeat (2) tick();
        end
        for (int i = 0; i < 10 && state != 3'd3; i++) tick();
        repeat (3) tick();
        checks++;
        if (dut_vec() !== mdl_vec() || state !== 3'd3) begin
            errors++; $display("FAIL stop_handover: got %h expected %h", dut_vec(), mdl_vec());
        end
        reset = 1'b0;
        tick();
        checks++;
        if (dut_vec() !== 17'd0) begin
            errors++; $display("FAIL reset_in_handover: got %h expected 0", dut_vec());
        end
        reset = 1'b1; start = 1'b0;
        tick();
        checks++;
        if (dut_vec() !== mdl_vec()) begin
            errors++; $display("FAIL reset_release: got %h expected %h", dut_vec(), mdl_vec());
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_fault();
        test_invalid_hall();
        test_stall_wrap();
        test_stop_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
